// File: rtl/alu_cmd_sequencer.sv
// Sequences single ALU commands: load operands, capture the result, then hold a response until it is taken.
// Define ALU_SEQ_CHAIN_EN to let a command take operand A from the previous response (last-result register).
module alu_cmd_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_chain,
    output logic [2:0] in_selector,
    output logic [7:0] num1,
    output logic [7:0] num2,
    output logic [6:0] out_selector,
    input  logic [7:0] alu_result,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_error,
    output logic [7:0] rsp_count,
    output logic       busy
);
    localparam logic [2:0] OP_MULT    = 3'd6;
    localparam logic [2:0] OP_INVALID = 3'd7;
    localparam logic [2:0] SEL_LOAD   = 3'b010;
    localparam logic [2:0] SEL_CLEAR  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_error_q, rsp_error_d;
    logic [7:0] rsp_count_q, rsp_count_d;

    logic       cmd_fire;
    logic       rsp_fire;
    logic [6:0] op_onehot;
    logic [7:0] operand_a;

    assign cmd_fire = (state_q == ST_IDLE) && cmd_valid;
    assign rsp_fire = (state_q == ST_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_op == OP_INVALID) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // op code N lights out_selector bit (6 - N); op 7 never reaches ISSUE/CAPTURE
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_op_decode
            assign op_onehot[6-gi] = (op_q == 3'(gi));
        end
    endgenerate

`ifdef ALU_SEQ_CHAIN_EN
    logic       chain_q, chain_d;
    logic [7:0] last_result_q, last_result_d;

    always_comb begin
        chain_d       = chain_q;
        last_result_d = last_result_q;
        if (cmd_fire) begin
            chain_d = cmd_chain;
        end
        if (rsp_fire) begin
            last_result_d = rsp_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q       <= 1'b0;
            last_result_q <= 8'h00;
        end else begin
            chain_q       <= chain_d;
            last_result_q <= last_result_d;
        end
    end

    assign operand_a = chain_q ? last_result_q : a_q;
`else
    logic unused_cmd_chain;
    assign unused_cmd_chain = cmd_chain;
    assign operand_a        = a_q;
`endif

    always_comb begin
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        rsp_count_d = rsp_count_q;
        if (cmd_fire) begin
            op_d = cmd_op;
            a_d  = cmd_a;
            b_d  = cmd_b;
            // invalid ops skip the ALU and answer with a fixed error response
            if (cmd_op == OP_INVALID) begin
                rsp_data_d  = 8'h00;
                rsp_error_d = 1'b1;
            end
        end
        if (state_q == ST_CAPTURE) begin
            rsp_data_d  = alu_result;
            rsp_error_d = (op_q == OP_MULT) ? alu_overflow : 1'b0;
        end
        if (rsp_fire) begin
            rsp_count_d = rsp_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q        <= 3'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            rsp_data_q  <= 8'h00;
            rsp_error_q <= 1'b0;
            rsp_count_q <= 8'h00;
        end else begin
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            rsp_count_q <= rsp_count_d;
        end
    end

    always_comb begin
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        in_selector  = SEL_CLEAR;
        num1         = 8'h00;
        num2         = 8'h00;
        out_selector = 7'd0;
        rsp_valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_ISSUE: begin
                in_selector  = SEL_LOAD;
                num1         = operand_a;
                num2         = b_q;
                out_selector = op_onehot;
            end
            ST_CAPTURE: begin
                out_selector = op_onehot;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;
    assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed cases plus random commands against a reference model.
// A simple load/compute ALU is modelled here so the sequencer sees realistic alu_result/alu_overflow.
module tb_alu_cmd_sequencer;
`ifdef ALU_SEQ_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_chain;
    logic [2:0] in_selector;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [6:0] out_selector;
    logic [7:0] alu_result;
    logic       alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_error;
    logic [7:0] rsp_count;
    logic       busy;

    int         checks;
    int         failures;
    int         txn;
    logic [7:0] exp_count;
    logic [7:0] last_res;

    alu_cmd_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_chain    (cmd_chain),
        .in_selector  (in_selector),
        .num1         (num1),
        .num2         (num2),
        .out_selector (out_selector),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .rsp_count    (rsp_count),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // external ALU: operands latch on load, clear on clear, result follows the one-hot op select
    logic [7:0]  alu_a_q;
    logic [7:0]  alu_b_q;
    logic [15:0] alu_prod;

    always @(posedge clk) begin
        if (in_selector == 3'b010) begin
            alu_a_q <= num1;
            alu_b_q <= num2;
        end else if (in_selector == 3'b001) begin
            alu_a_q <= 8'h00;
            alu_b_q <= 8'h00;
        end
    end

    always_comb begin
        alu_prod     = 16'(alu_a_q) * 16'(alu_b_q);
        alu_result   = 8'h00;
        alu_overflow = 1'b0;
        if (out_selector[6])      alu_result = alu_a_q & alu_b_q;
        else if (out_selector[5]) alu_result = alu_a_q | alu_b_q;
        else if (out_selector[4]) alu_result = ~alu_a_q;
        else if (out_selector[3]) alu_result = alu_a_q ^ alu_b_q;
        else if (out_selector[2]) alu_result = alu_a_q + alu_b_q;
        else if (out_selector[1]) alu_result = alu_a_q - alu_b_q;
        else if (out_selector[0]) begin
            alu_result   = alu_prod[7:0];
            alu_overflow = |alu_prod[15:8];
        end
    end

    // expected {error, data} for one command, from plain integer arithmetic
    function automatic logic [8:0] ref_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ai;
        int bi;
        int r;
        bit err;
        ai  = int'(a);
        bi  = int'(b);
        r   = 0;
        err = 1'b0;
        case (op)
            3'd0: r = ai & bi;
            3'd1: r = ai | bi;
            3'd2: r = 255 - ai;
            3'd3: r = ai ^ bi;
            3'd4: r = (ai + bi) % 256;
            3'd5: r = (ai - bi + 256) % 256;
            3'd6: begin
                r   = (ai * bi) % 256;
                err = (ai * bi) > 255;
            end
            default: begin
                r   = 0;
                err = 1'b1;
            end
        endcase
        return {err, 8'(r)};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic chain, input int hold, input bit force_valid);
        logic [7:0] exp_a;
        logic [8:0] exp_rsp;
        logic [6:0] exp_sel;
        exp_a   = (CHAIN_EN && chain) ? last_res : a;
        exp_rsp = ref_rsp(op, exp_a, b);
        exp_sel = (op == 3'd7) ? 7'd0 : 7'(7'h40 >> op);

        check("idle_cmd_ready", 16'(cmd_ready), 16'd1);
        check("idle_busy", 16'(busy), 16'd0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = chain;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 3'($urandom);
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_chain = 1'($urandom_range(0, 1));

        if (op != 3'd7) begin
            rsp_ready = 1'($urandom_range(0, 1));
            check("issue_in_sel", 16'(in_selector), 16'(3'b010));
            check("issue_num1", 16'(num1), 16'(exp_a));
            check("issue_num2", 16'(num2), 16'(b));
            check("issue_out_sel", 16'(out_selector), 16'(exp_sel));
            check("issue_rsp_valid", 16'(rsp_valid), 16'd0);
            check("issue_cmd_ready", 16'(cmd_ready), 16'd0);
            check("issue_busy", 16'(busy), 16'd1);
            @(negedge clk);
            rsp_ready = 1'($urandom_range(0, 1));
            check("capt_in_sel", 16'(in_selector), 16'(3'b001));
            check("capt_num1", 16'(num1), 16'd0);
            check("capt_num2", 16'(num2), 16'd0);
            check("capt_out_sel", 16'(out_selector), 16'(exp_sel));
            check("capt_rsp_valid", 16'(rsp_valid), 16'd0);
            @(negedge clk);
        end

        check("resp_valid", 16'(rsp_valid), 16'd1);
        check("resp_data", 16'(rsp_data), 16'(exp_rsp[7:0]));
        check("resp_error", 16'(rsp_error), 16'(exp_rsp[8]));
        check("resp_in_sel", 16'(in_selector), 16'(3'b001));
        check("resp_out_sel", 16'(out_selector), 16'd0);
        check("resp_cmd_ready", 16'(cmd_ready), 16'd0);
        check("resp_busy", 16'(busy), 16'd1);

        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            if (force_valid) cmd_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", 16'(rsp_valid), 16'd1);
            check("hold_data", 16'(rsp_data), 16'(exp_rsp[7:0]));
            check("hold_error", 16'(rsp_error), 16'(exp_rsp[8]));
            check("hold_cmd_ready", 16'(cmd_ready), 16'd0);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        exp_count = exp_count + 8'd1;
        if (CHAIN_EN) last_res = exp_rsp[7:0];
        check("done_rsp_valid", 16'(rsp_valid), 16'd0);
        check("done_rsp_count", 16'(rsp_count), 16'(exp_count));
        check("done_busy", 16'(busy), 16'd0);
        txn++;
        $display("txn %0d op=%0d a=%02h b=%02h chain=%0b hold=%0d exp_data=%02h exp_err=%0b got_count=%0d",
                 txn, op, a, b, chain, hold, exp_rsp[7:0], exp_rsp[8], rsp_count);
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_cmd_ready"}, 16'(cmd_ready), 16'd1);
        check({phase, "_busy"}, 16'(busy), 16'd0);
        check({phase, "_rsp_valid"}, 16'(rsp_valid), 16'd0);
        check({phase, "_rsp_data"}, 16'(rsp_data), 16'd0);
        check({phase, "_rsp_error"}, 16'(rsp_error), 16'd0);
        check({phase, "_rsp_count"}, 16'(rsp_count), 16'd0);
        check({phase, "_in_sel"}, 16'(in_selector), 16'(3'b001));
        check({phase, "_out_sel"}, 16'(out_selector), 16'd0);
        check({phase, "_num1"}, 16'(num1), 16'd0);
        check({phase, "_num2"}, 16'(num2), 16'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        txn       = 0;
        exp_count = 8'h00;
        last_res  = 8'h00;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_chain = 1'b0;
        rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;
        @(negedge clk);

        run_cmd(3'd4, 8'h7F, 8'h01, 1'b0, 0, 1'b0);
        run_cmd(3'd6, 8'h10, 8'h10, 1'b0, 1, 1'b0);
        run_cmd(3'd6, 8'h0F, 8'h0F, 1'b0, 0, 1'b0);
        run_cmd(3'd7, 8'hAB, 8'hCD, 1'b0, 2, 1'b0);
        run_cmd(3'd3, 8'h5A, 8'hC3, 1'b0, 10, 1'b1);
        run_cmd(3'd2, 8'h3C, 8'h00, 1'b1, 0, 1'b0);
`ifdef ALU_SEQ_CHAIN_EN
        run_cmd(3'd4, 8'h05, 8'h03, 1'b0, 0, 1'b0);
        run_cmd(3'd5, 8'hAA, 8'h02, 1'b1, 1, 1'b0);
`endif

        // reset while the ALU result is being captured
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_a     = 8'h21;
        cmd_b     = 8'h12;
        cmd_chain = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_out_sel", 16'(out_selector), 16'(7'b0000100));
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_count = 8'h00;
        last_res  = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_rsp", 16'(rsp_valid), 16'd0);
        end

        for (int n = 0; n < 300; n++) begin
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
